// File: rtl/prbs31_checker.sv
// Self-synchronizing parallel PRBS-31 (x^31+x^28+1) checker: seeds from the
// received data, confirms lock over clean words, then counts bit errors.
module prbs31_checker #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned MSB_FIRST    = 0,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 4,
  parameter int unsigned ERR_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  input  logic [WIDTH-1:0]     din,
  input  logic                 clear_counts,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [47:0]          word_count
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned SW = ((ERR_WIDTH > CW) ? ERR_WIDTH : CW) + 1;
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;
  localparam logic [7:0] LOCK8   = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK8 = 8'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_CONFIRM,
    ST_LOCKED
  } state_t;

  state_t               state_q, state_d;
  logic [30:0]          lfsr_q, lfsr_d;
  logic [7:0]           clean_q, clean_d;
  logic [7:0]           bad_q, bad_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic [47:0]          words_q, words_d;
  logic                 pulse_q, pulse_d;

  logic [WIDTH-1:0]     pred;
  logic [WIDTH-1:0]     mask;
  logic [30:0]          lfsr_adv;
  logic [30:0]          seed;
  logic                 seed_nz;
  logic [CW-1:0]        weight;
  logic [SW-1:0]        err_sum;
  logic [ERR_WIDTH-1:0] err_sat;

  // Unrolled bit-serial reference: state[0] newest, each new bit shifts in at 0.
  always_comb begin
    logic [30:0] s;
    logic        b;
    s    = lfsr_q;
    pred = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      b = s[30] ^ s[27];
      s = {s[29:0], b};
      if (MSB_FIRST != 0) pred[WIDTH-1-i] = b;
      else                pred[i]         = b;
    end
    lfsr_adv = s;
  end

  always_comb begin
    seed = '0;
    for (int unsigned i = 0; i < 31; i++) begin
      if (MSB_FIRST != 0) seed[i] = din[i];
      else                seed[i] = din[WIDTH-1-i];
    end
    seed_nz = |seed;
  end

  assign mask = din ^ pred;

  always_comb begin
    weight = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      weight = weight + CW'(mask[i]);
    end
  end

  always_comb begin
    err_sum = SW'(err_q) + SW'(weight);
    err_sat = (err_sum > SW'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    clean_d = clean_q;
    bad_d   = bad_q;
    err_d   = err_q;
    words_d = words_q;
    pulse_d = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        ST_UNLOCKED: begin
          if (seed_nz) begin
            lfsr_d  = seed;
            clean_d = '0;
            state_d = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (weight == '0) begin
            lfsr_d  = lfsr_adv;
            clean_d = clean_q + 8'd1;
            if (clean_d == LOCK8) begin
              state_d = ST_LOCKED;
              bad_d   = '0;
            end
          end else if (seed_nz) begin
            lfsr_d  = seed;
            clean_d = '0;
          end else begin
            clean_d = '0;
            state_d = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          // Free-run from the prediction so one flipped bit is counted once.
          lfsr_d  = lfsr_adv;
          err_d   = err_sat;
          words_d = words_q + 48'd1;
          if (weight != '0) begin
            pulse_d = 1'b1;
            bad_d   = bad_q + 8'd1;
            if (bad_d == UNLOCK8) begin
              bad_d   = '0;
              state_d = ST_UNLOCKED;
            end
          end else begin
            bad_d = '0;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
    if (clear_counts) begin
      err_d   = '0;
      words_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_UNLOCKED;
      lfsr_q  <= '0;
      clean_q <= '0;
      bad_q   <= '0;
      err_q   <= '0;
      words_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      clean_q <= clean_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      words_q <= words_d;
      pulse_q <= pulse_d;
    end
  end

  assign locked     = (state_q == ST_LOCKED);
  assign err_pulse  = pulse_q;
  assign err_count  = err_q;
  assign word_count = words_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboard bench for prbs31_checker: default, ERR_WIDTH=4 and MSB-first
// instances share one stimulus stream (MSB-first copy gets bit-reversed words).
module tb_prbs31_checker;

  logic        clk;
  logic        rst_n;
  logic        din_valid;
  logic [31:0] din;
  logic [31:0] din_m;
  logic        clear_counts;

  logic        lk_a, pl_a, lk_s, pl_s, lk_m, pl_m;
  logic [31:0] ec_a, ec_m;
  logic [3:0]  ec_s;
  logic [47:0] wc_a, wc_s, wc_m;

  prbs31_checker u_dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .clear_counts(clear_counts), .locked(lk_a), .err_pulse(pl_a),
    .err_count(ec_a), .word_count(wc_a)
  );

  prbs31_checker #(.ERR_WIDTH(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .clear_counts(clear_counts), .locked(lk_s), .err_pulse(pl_s),
    .err_count(ec_s), .word_count(wc_s)
  );

  prbs31_checker #(.MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din_m),
    .clear_counts(clear_counts), .locked(lk_m), .err_pulse(pl_m),
    .err_count(ec_m), .word_count(wc_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lk;
    logic        pl;
    logic [31:0] ec;
    logic [3:0]  ec4;
    logic [47:0] wc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream generator (independent of the checker's reference model state)
  logic [30:0] g;

  function automatic logic [31:0] gen_word(inout logic [30:0] s);
    logic [31:0] w;
    logic        b;
    for (int i = 0; i < 32; i++) begin
      b    = s[30] ^ s[27];
      s    = {s[29:0], b};
      w[i] = b;
    end
    return w;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = d[31-i];
    return r;
  endfunction

  function automatic int popc(input logic [31:0] d);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(d[i]);
    return n;
  endfunction

  // Reference checker model
  int          m_st;      // 0 unlocked, 1 confirm, 2 locked
  logic [30:0] m_lfsr;
  int          m_clean, m_bad;
  longint      m_errc;
  logic [47:0] m_wc;
  logic        m_pl;

  task automatic model(input logic rst, input logic v, input logic [31:0] d, input logic clr);
    logic [30:0] s, sd;
    logic [31:0] p;
    int          w;
    if (!rst) begin
      m_st = 0; m_lfsr = '0; m_clean = 0; m_bad = 0; m_errc = 0; m_wc = '0; m_pl = 1'b0;
      return;
    end
    m_pl = 1'b0;
    if (v) begin
      s = m_lfsr;
      p = gen_word(s);
      for (int i = 0; i < 31; i++) sd[i] = d[31-i];
      case (m_st)
        0: if (sd != '0) begin m_lfsr = sd; m_clean = 0; m_st = 1; end
        1: begin
          if (d == p) begin
            m_lfsr = s; m_clean++;
            if (m_clean == 4) begin m_st = 2; m_bad = 0; end
          end else if (sd != '0) begin
            m_lfsr = sd; m_clean = 0;
          end else begin
            m_clean = 0; m_st = 0;
          end
        end
        default: begin
          w = popc(d ^ p);
          m_lfsr = s;
          m_errc += w;
          m_wc = m_wc + 48'd1;
          if (w != 0) begin
            m_pl = 1'b1; m_bad++;
            if (m_bad == 4) begin m_st = 0; m_bad = 0; end
          end else m_bad = 0;
        end
      endcase
    end
    if (clr) begin m_errc = 0; m_wc = '0; end
  endtask

  task automatic step(input logic rst, input logic v, input logic [31:0] d, input logic clr);
    exp_t e, o;
    @(negedge clk);
    rst_n = rst; din_valid = v; din = d; din_m = rev32(d); clear_counts = clr;
    model(rst, v, d, clr);
    e.lk  = (m_st == 2);
    e.pl  = m_pl;
    e.ec  = (m_errc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_errc[31:0];
    e.ec4 = (m_errc > 15) ? 4'hF : m_errc[3:0];
    e.wc  = m_wc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      o = sb.pop_front();
      check("locked", lk_a, o.lk);
      check("err_pulse", pl_a, o.pl);
      check("err_count", ec_a, o.ec);
      check("word_count", wc_a, o.wc);
      check("sat_locked", lk_s, o.lk);
      check("sat_err_count", ec_s, o.ec4);
      check("sat_word_count", wc_s, o.wc);
      check("msb_locked", lk_m, o.lk);
      check("msb_err_pulse", pl_m, o.pl);
      check("msb_err_count", ec_m, o.ec);
      check("msb_word_count", wc_m, o.wc);
    end
  endtask

  task automatic stream(input int n, input logic [31:0] x);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, gen_word(g) ^ x, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; din_valid = 1'b0; din = '0; din_m = '0; clear_counts = 1'b0;
    g = 31'h1;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // Idle zeros must never seed
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'h0, 1'b0);
    check("zero_idle_locked", lk_a, 0);

    // Acquire: seed word plus four clean words
    stream(4, 32'h0);
    check("pre_lock", lk_a, 0);
    stream(1, 32'h0);
    check("lock_after_5", lk_a, 1);
    stream(4, 32'h0);

    // Single and triple bit errors, no multiplication afterwards
    stream(1, 32'h0000_0001);
    check("pulse_1bit", pl_a, 1);
    check("err_1bit", ec_a, 1);
    stream(1, 32'h8000_0101);
    check("err_4bits", ec_a, 4);
    stream(3, 32'h0);
    check("err_no_mult", ec_a, 4);

    // Four fully corrupted words drop lock, then relock on the clean stream
    stream(3, 32'hFFFF_FFFF);
    check("still_locked_3bad", lk_a, 1);
    stream(1, 32'hFFFF_FFFF);
    check("unlock_4bad", lk_a, 0);
    check("err_plus_128", ec_a, 132);
    stream(4, 32'h0);
    check("relock_pending", lk_a, 0);
    stream(1, 32'h0);
    check("relock", lk_a, 1);

    // Clear wins over a counted word
    step(1'b1, 1'b1, gen_word(g) ^ 32'h0000_0010, 1'b1);
    check("clear_err", ec_a, 0);
    check("clear_wc", wc_a, 0);

    // Six-bit errors on clean-separated words saturate the 4-bit counter
    stream(1, 32'h0000_003F);
    stream(2, 32'h0);
    stream(1, 32'h0000_003F);
    stream(1, 32'h0);
    stream(1, 32'h0000_003F);
    check("sat_15", ec_s, 15);
    check("nosat_18", ec_a, 18);
    stream(2, 32'h0);

    // Gapped valid stream after reset: same lock timing in valid words
    step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, gen_word(g), 1'b0);
      step(1'b1, 1'b0, $urandom, 1'b0);
    end
    check("gapped_locked", lk_a, 1);
    check("gapped_wc", wc_a, 3);

    // Reset mid-lock clears everything at once
    step(1'b0, 1'b1, gen_word(g), 1'b0);
    check("rst_locked", lk_a, 0);
    check("rst_wc", wc_a, 0);
    stream(3, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Self-synchronizing parallel PRBS-31 checker (polynomial x^31+x^28+1), consumed downstream of the PRBS-31 generator, typically behind a SERDES RX datapath for link BER testing.
- Seeds its internal LFSR from received data, confirms lock over several clean words, then free-runs the reference and counts bit errors.
- Bit ordering matches the generator exactly.

Parameters:
- WIDTH, 32, data word width in bits; must be >=31 so one word fully seeds the LFSR.
- MSB_FIRST, 0, 1 = din[WIDTH-1] is the oldest bit in time; 0 = din[0] is the oldest.
- LOCK_COUNT, 4, consecutive error-free words required in CONFIRM before asserting lock (1..255).
- UNLOCK_COUNT, 4, consecutive errored words in LOCKED that force loss of lock (1..255).
- ERR_WIDTH, 32, width of the saturating bit-error counter.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous active-low reset.
- din_valid  in  1  din holds a valid word this cycle.
- din  in  WIDTH  received data word.
- clear_counts  in  1  zero err_count and word_count; lock state unaffected.
- locked  out  1  checker locked to the sequence.
- err_pulse  out  1  one-cycle high when a LOCKED-state word had >=1 bit error.
- err_count  out  ERR_WIDTH  saturating total bit errors counted while LOCKED.
- word_count  out  48  words checked while LOCKED (wraps).

Behaviour:
- Reset (rst_n low at a clock edge): state UNLOCKED, LFSR = 0, locked = 0, err_pulse = 0, err_count = 0, word_count = 0, run counters = 0. Reset mid-lock discards lock immediately.
- Prediction: from 31-bit state (state[0] newest, state[30] oldest), generate WIDTH bits as b = state[30]^state[27], shifting b into state[0] per bit. Placement follows MSB_FIRST: LSB-first puts the i-th generated bit in pred[i]; MSB-first puts it in pred[WIDTH-1-i].
- Seeding: load state from the newest 31 received bits. MSB_FIRST=0: state[i] = din[WIDTH-1-i]. MSB_FIRST=1: state[i] = din[i].
- Error mask: din ^ pred. Error weight: popcount of the mask, 0..WIDTH.
- Words with din_valid=0 are ignored entirely: no state advance and no counter change.
- FSM:
  - UNLOCKED: on a valid word, if din's seed bits are nonzero, seed and go to CONFIRM with clean-run = 0. An all-zero seed is rejected and the FSM stays UNLOCKED, which prevents a false lock on idle zeros.
  - CONFIRM: on a valid word, compare against pred.
    - Clean word: advance state, increment clean-run. When the run reaches LOCK_COUNT, go to LOCKED.
    - Errored word: reseed from this word (subject to the zero check; an all-zero seed returns to UNLOCKED) and reset clean-run.
  - LOCKED: on a valid word, the state always advances with pred, never din, so a single flipped bit counts exactly once.
    - err_count += weight, saturating at 2^ERR_WIDTH-1. word_count += 1.
    - Errored word: err_pulse = 1, increment bad-run. Clean word: bad-run = 0.
    - When bad-run reaches UNLOCK_COUNT, go to UNLOCKED and deassert locked. That final word's errors are still counted.
- Latency: all outputs are registered and reflect the din of cycle N at cycle N+1. locked rises in the cycle after the LOCK_COUNT-th clean confirm word.
- Simultaneous clear_counts with a counted word: the clear wins, and counters read 0 the next cycle. The word is still used for FSM and run tracking.
- err_pulse is 0 in any cycle without a valid LOCKED-state word.

Test Plan:
- Generator (WIDTH=32, LSB-first, seed 31'h1) streams words continuously -> locked=0 through word 5, locked=1 the cycle after word 5 (1 seed word + 4 clean words), err_count stays 0, word_count increments by 1 per word.
- After lock, XOR 32'h0000_0001 into one word -> err_pulse=1 for one cycle, err_count=1, locked stays 1. XOR 32'h8000_0101 into the next word -> err_count=4, and following words are clean (no error multiplication).
- Corrupt 4 consecutive words with 32'hFFFF_FFFF -> err_count +128, locked=0 after the 4th word. Then resume the clean stream -> relock after 5 more words.
- Hold din=0 with din_valid=1 for 20 cycles from reset -> locked stays 0, FSM never leaves UNLOCKED.
- Deassert din_valid every other cycle with the same stream -> identical lock timing in valid-word count, no errors. Pulse clear_counts while locked -> err_count=0 and word_count=0 next cycle.
- Run with ERR_WIDTH=4, inject 6 errors per word for 3 clean-separated words -> err_count saturates at 15. Drop rst_n mid-lock -> next cycle all outputs 0; run MSB_FIRST=1 against an MSB-first generator -> locks identically.
